// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer that splits word-crossing accesses into two
// word-aligned bus beats, merging and extending load data.
`default_nettype none

module lsu_seq #(
  parameter int unsigned TMO = 255
) (
  input  logic        CLK,
  input  logic        RESN,
  input  logic        REQ,
  input  logic        WR,
  input  logic [2:0]  FCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        ACK,
  output logic        ERR,
  output logic        BUSY,
  output logic [31:0] DADDR,
  output logic        DRD,
  output logic        DWR,
  output logic [3:0]  BE,
  output logic [31:0] DATAO,
  input  logic [31:0] DATAI,
  input  logic        DACK
);

  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        wr_q;
  logic [2:0]  fct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] lo, lo_n, hi, hi_n;

  logic [31:0] rdata_n, daddr_n, datao_n;
  logic        ack_n, err_n, busy_n, drd_n, dwr_n;
  logic [3:0]  be_n;

  // In IDLE the lane/store vectors are built from the live inputs so the
  // first beat can be registered on the accepting edge.
  logic [31:0] a_s, wd_s;
  logic [2:0]  f_s;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [7:0]  lanes;
  logic        split;
  logic [31:0] wsized;
  logic [63:0] svec;
  logic [31:0] lo_eff, hi_eff, merged, ld;
  logic        tmo_hit;

  assign a_s  = (state == S_IDLE) ? ADDR  : addr_q;
  assign wd_s = (state == S_IDLE) ? WDATA : wdata_q;
  assign f_s  = (state == S_IDLE) ? FCT3  : fct3_q;
  assign off  = a_s[1:0];

  always_comb begin
    mask   = 4'b0001;
    wsized = {24'h0, wd_s[7:0]};
    if (f_s[1]) begin
      mask   = 4'b1111;
      wsized = wd_s;
    end else if (f_s[0]) begin
      mask   = 4'b0011;
      wsized = {16'h0, wd_s[15:0]};
    end
  end

  assign lanes = {4'b0000, mask} << off;
  assign split = |lanes[7:4];
  assign svec  = {32'h0, wsized} << {off, 3'b000};

  // The completing beat's data comes straight from the bus.
  assign lo_eff = (state == S_ACC0) ? DATAI : lo;
  assign hi_eff = (state == S_ACC1) ? DATAI : hi;
  assign merged = 32'({hi_eff, lo_eff} >> {off, 3'b000});

  always_comb begin
    ld = merged;
    if (!f_s[1]) begin
      if (f_s[0])
        ld = f_s[2] ? {16'h0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
      else
        ld = f_s[2] ? {24'h0, merged[7:0]} : {{24{merged[7]}}, merged[7:0]};
    end
  end

  assign tmo_hit = (TMO != 0) && (cnt == TMO_LAST);

  always_comb begin
    state_n = state;
    rdata_n = RDATA;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    busy_n  = BUSY;
    daddr_n = DADDR;
    drd_n   = DRD;
    dwr_n   = DWR;
    be_n    = BE;
    datao_n = DATAO;
    cnt_n   = cnt;
    lo_n    = lo;
    hi_n    = hi;
    case (state)
      S_IDLE: begin
        if (REQ) begin
          state_n = S_ACC0;
          busy_n  = 1'b1;
          daddr_n = {a_s[31:2], 2'b00};
          be_n    = lanes[3:0];
          datao_n = svec[31:0];
          drd_n   = ~WR;
          dwr_n   = WR;
          cnt_n   = '0;
        end
      end
      S_ACC0, S_ACC1: begin
        if (DACK) begin
          if (state == S_ACC0) lo_n = DATAI;
          else                 hi_n = DATAI;
          if (state == S_ACC0 && split) begin
            state_n = S_ACC1;
            daddr_n = DADDR + 32'd4;
            be_n    = lanes[7:4];
            datao_n = svec[63:32];
            cnt_n   = '0;
          end else begin
            state_n = S_DONE;
            drd_n   = 1'b0;
            dwr_n   = 1'b0;
            ack_n   = 1'b1;
            if (!wr_q) rdata_n = ld;
          end
        end else if (tmo_hit) begin
          state_n = S_DONE;
          drd_n   = 1'b0;
          dwr_n   = 1'b0;
          ack_n   = 1'b1;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESN) begin
      state   <= S_IDLE;
      wr_q    <= 1'b0;
      fct3_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      lo      <= '0;
      hi      <= '0;
      RDATA   <= '0;
      ACK     <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
      DADDR   <= '0;
      DRD     <= 1'b0;
      DWR     <= 1'b0;
      BE      <= '0;
      DATAO   <= '0;
    end else begin
      if (state == S_IDLE && REQ) begin
        wr_q    <= WR;
        fct3_q  <= FCT3;
        addr_q  <= ADDR;
        wdata_q <= WDATA;
      end
      state <= state_n;
      cnt   <= cnt_n;
      lo    <= lo_n;
      hi    <= hi_n;
      RDATA <= rdata_n;
      ACK   <= ack_n;
      ERR   <= err_n;
      BUSY  <= busy_n;
      DADDR <= daddr_n;
      DRD   <= drd_n;
      DWR   <= dwr_n;
      BE    <= be_n;
      DATAO <= datao_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_seq.sv
// Bench for lsu_seq: directed scenarios with an ACK-side result scoreboard.
`default_nettype none

module tb_lsu_seq;

  logic        CLK, RESN, REQ, WR, DACK;
  logic [2:0]  FCT3;
  logic [31:0] ADDR, WDATA, DATAI;
  logic [31:0] RDATA, DADDR, DATAO;
  logic        ACK, ERR, BUSY, DRD, DWR;
  logic [3:0]  BE;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  lsu_seq #(.TMO(4)) dut (
    .CLK(CLK), .RESN(RESN), .REQ(REQ), .WR(WR), .FCT3(FCT3), .ADDR(ADDR),
    .WDATA(WDATA), .RDATA(RDATA), .ACK(ACK), .ERR(ERR), .BUSY(BUSY),
    .DADDR(DADDR), .DRD(DRD), .DWR(DWR), .BE(BE), .DATAO(DATAO),
    .DATAI(DATAI), .DACK(DACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ACK === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ACK=1 with nothing outstanding, required ACK=0");
      end else begin
        e = sb.pop_front();
        if (ERR !== e.err || (e.chk_rd && RDATA !== e.rdata)) begin
          errors++;
          $display("FAIL ack_result: got RDATA=%h ERR=%b, required RDATA=%h ERR=%b",
                   RDATA, ERR, e.rdata, e.err);
        end
      end
    end
  end

  task automatic drive_req(input logic wr, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] wd);
    REQ = 1'b1; WR = wr; FCT3 = f; ADDR = a; WDATA = wd;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if ({RDATA, ACK, ERR, BUSY, DADDR, DRD, DWR, BE, DATAO} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got RDATA=%h ACK=%b ERR=%b BUSY=%b DADDR=%h DRD=%b DWR=%b BE=%b DATAO=%h, required all 0",
               RDATA, ACK, ERR, BUSY, DADDR, DRD, DWR, BE, DATAO);
    end
    RESN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_aligned_lw();
    drive_req(1'b0, 3'b010, 32'h100, 32'h0);
    DACK = 1'b1; DATAI = 32'hDEADBEEF;
    sb.push_back({32'hDEADBEEF, 1'b0, 1'b1});
    @(negedge CLK); REQ = 1'b0;
    checks++;
    if ({DRD, DWR, BE, DADDR, BUSY, ACK} !== {1'b1, 1'b0, 4'b1111, 32'h100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lw_beat: got DRD=%b DWR=%b BE=%b DADDR=%h BUSY=%b ACK=%b, required 1 0 1111 00000100 1 0",
               DRD, DWR, BE, DADDR, BUSY, ACK);
    end
    @(negedge CLK);
    checks++;
    if ({ACK, DRD, BUSY} !== 3'b101) begin
      errors++;
      $display("FAIL lw_ack_cycle: got ACK=%b DRD=%b BUSY=%b, required 1 0 1", ACK, DRD, BUSY);
    end
    @(negedge CLK);
    checks++;
    if ({ACK, BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL lw_idle: got ACK=%b BUSY=%b, required 0 0", ACK, BUSY);
    end
  endtask

  task automatic test_byte_loads();
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b0, (i == 1) ? 3'b100 : 3'b000, 32'h103, 32'h0);
      DACK = 1'b1; DATAI = 32'h80000000;
      sb.push_back({(i == 1) ? 32'h00000080 : 32'hFFFFFF80, 1'b0, 1'b1});
      @(negedge CLK); REQ = 1'b0;
      checks++;
      if ({DADDR, BE, DRD} !== {32'h100, 4'b1000, 1'b1}) begin
        errors++;
        $display("FAIL lb_beat[%0d]: got DADDR=%h BE=%b DRD=%b, required 00000100 1000 1", i, DADDR, BE, DRD);
      end
      @(negedge CLK);
      checks++;
      if (ACK !== 1'b1) begin
        errors++;
        $display("FAIL lb_ack[%0d]: got ACK=%b, required 1", i, ACK);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_misaligned_sw();
    drive_req(1'b1, 3'b010, 32'h102, 32'h11223344);
    DACK = 1'b1;
    sb.push_back({32'h0, 1'b0, 1'b0});
    @(negedge CLK); REQ = 1'b0;
    checks++;
    if ({DWR, DRD, DADDR, BE, DATAO} !== {1'b1, 1'b0, 32'h100, 4'b1100, 32'h33440000}) begin
      errors++;
      $display("FAIL sw_beat0: got DWR=%b DRD=%b DADDR=%h BE=%b DATAO=%h, required 1 0 00000100 1100 33440000",
               DWR, DRD, DADDR, BE, DATAO);
    end
    @(negedge CLK);
    checks++;
    if ({DWR, DADDR, BE, DATAO, ACK} !== {1'b1, 32'h104, 4'b0011, 32'h00001122, 1'b0}) begin
      errors++;
      $display("FAIL sw_beat1: got DWR=%b DADDR=%h BE=%b DATAO=%h ACK=%b, required 1 00000104 0011 00001122 0",
               DWR, DADDR, BE, DATAO, ACK);
    end
    @(negedge CLK);
    checks++;
    if ({ACK, DWR} !== 2'b10) begin
      errors++;
      $display("FAIL sw_ack: got ACK=%b DWR=%b, required 1 0", ACK, DWR);
    end
    @(negedge CLK);
  endtask

  task automatic test_misaligned_lh();
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b0, (i == 1) ? 3'b101 : 3'b001, 32'h1FF, 32'h0);
      DACK = 1'b1; DATAI = 32'hAB000000;
      sb.push_back({(i == 1) ? 32'h0000CDAB : 32'hFFFFCDAB, 1'b0, 1'b1});
      @(negedge CLK); REQ = 1'b0;
      checks++;
      if ({DADDR, BE, DRD} !== {32'h1FC, 4'b1000, 1'b1}) begin
        errors++;
        $display("FAIL lh_beat0[%0d]: got DADDR=%h BE=%b DRD=%b, required 000001fc 1000 1", i, DADDR, BE, DRD);
      end
      @(negedge CLK);
      DATAI = 32'h000000CD;
      checks++;
      if ({DADDR, BE, DRD, ACK} !== {32'h200, 4'b0001, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL lh_beat1[%0d]: got DADDR=%h BE=%b DRD=%b ACK=%b, required 00000200 0001 1 0", i, DADDR, BE, DRD, ACK);
      end
      @(negedge CLK);
      checks++;
      if (ACK !== 1'b1) begin
        errors++;
        $display("FAIL lh_ack[%0d]: got ACK=%b, required 1", i, ACK);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_wait_states();
    drive_req(1'b0, 3'b010, 32'h108, 32'h0);
    DACK = 1'b0; DATAI = 32'h12345678;
    sb.push_back({32'h12345678, 1'b0, 1'b1});
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK); REQ = 1'b0;
      if (c == 3) DACK = 1'b1;
      checks++;
      if ({DRD, ACK} !== 2'b10) begin
        errors++;
        $display("FAIL wait_strobe[%0d]: got DRD=%b ACK=%b, required 1 0", c, DRD, ACK);
      end
    end
    @(negedge CLK);
    checks++;
    if ({ACK, DRD} !== 2'b10) begin
      errors++;
      $display("FAIL wait_ack: got ACK=%b DRD=%b, required 1 0", ACK, DRD);
    end
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b0, 3'b010, (i == 1) ? 32'h102 : 32'h100, 32'h0);
      DACK = 1'b0; DATAI = 32'hFFFFFFFF;
      sb.push_back({32'h0, 1'b1, 1'b1});
      for (int c = 1; c <= 4; c++) begin
        @(negedge CLK); REQ = 1'b0;
        checks++;
        if ({DRD, DADDR, ACK} !== {1'b1, 32'h100, 1'b0}) begin
          errors++;
          $display("FAIL tmo_strobe[%0d][%0d]: got DRD=%b DADDR=%h ACK=%b, required 1 00000100 0", i, c, DRD, DADDR, ACK);
        end
      end
      @(negedge CLK);
      checks++;
      if ({ACK, ERR, DRD} !== 3'b110) begin
        errors++;
        $display("FAIL tmo_ack[%0d]: got ACK=%b ERR=%b DRD=%b, required 1 1 0", i, ACK, ERR, DRD);
      end
      @(negedge CLK);
      checks++;
      if ({DRD, ACK, BUSY} !== 3'b000) begin
        errors++;
        $display("FAIL tmo_no_beat1[%0d]: got DRD=%b ACK=%b BUSY=%b, required 0 0 0", i, DRD, ACK, BUSY);
      end
    end
  endtask

  task automatic test_wrap_reset();
    drive_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    DACK = 1'b1; DATAI = 32'h11111111;
    sb.push_back({32'h22221111, 1'b0, 1'b1});
    @(negedge CLK); REQ = 1'b0;
    checks++;
    if ({DADDR, BE} !== {32'hFFFFFFFC, 4'b1100}) begin
      errors++;
      $display("FAIL wrap_beat0: got DADDR=%h BE=%b, required fffffffc 1100", DADDR, BE);
    end
    @(negedge CLK);
    DATAI = 32'h22222222;
    checks++;
    if ({DADDR, BE, DRD} !== {32'h0, 4'b0011, 1'b1}) begin
      errors++;
      $display("FAIL wrap_beat1: got DADDR=%h BE=%b DRD=%b, required 00000000 0011 1", DADDR, BE, DRD);
    end
    @(negedge CLK);
    @(negedge CLK);

    // Reset while the second beat is stalled
    drive_req(1'b0, 3'b010, 32'h1FE, 32'h0);
    DACK = 1'b1; DATAI = 32'h33333333;
    @(negedge CLK); REQ = 1'b0;
    @(negedge CLK);
    checks++;
    if ({DADDR, DRD} !== {32'h200, 1'b1}) begin
      errors++;
      $display("FAIL rst_in_acc1: got DADDR=%h DRD=%b, required 00000200 1", DADDR, DRD);
    end
    DACK = 1'b0; RESN = 1'b0;
    @(negedge CLK);
    checks++;
    if ({RDATA, ACK, ERR, BUSY, DADDR, DRD, DWR, BE, DATAO} !== '0) begin
      errors++;
      $display("FAIL rst_abandon: got RDATA=%h ACK=%b ERR=%b BUSY=%b DADDR=%h DRD=%b DWR=%b BE=%b DATAO=%h, required all 0",
               RDATA, ACK, ERR, BUSY, DADDR, DRD, DWR, BE, DATAO);
    end
    RESN = 1'b1;
    drive_req(1'b0, 3'b010, 32'h104, 32'h0);
    DACK = 1'b1; DATAI = 32'h0BADF00D;
    sb.push_back({32'h0BADF00D, 1'b0, 1'b1});
    @(negedge CLK); REQ = 1'b0;
    checks++;
    if ({DRD, DADDR, BE} !== {1'b1, 32'h104, 4'b1111}) begin
      errors++;
      $display("FAIL post_rst_beat: got DRD=%b DADDR=%h BE=%b, required 1 00000104 1111", DRD, DADDR, BE);
    end
    @(negedge CLK);
    checks++;
    if (ACK !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_ack: got ACK=%b, required 1", ACK);
    end
    @(negedge CLK);
  endtask

  initial begin
    RESN = 1'b0; REQ = 1'b0; WR = 1'b0; FCT3 = 3'b000;
    ADDR = '0; WDATA = '0; DATAI = '0; DACK = 1'b0;
    test_reset();
    test_aligned_lw();
    test_byte_loads();
    test_misaligned_sw();
    test_misaligned_lh();
    test_wait_states();
    test_timeout();
    test_wrap_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
